// File: rtl/ccip_mem_read_engine.sv
// CCI-P c0 host-memory read engine: streams tagged single-line reads and folds responses into a 64-bit XOR checksum.
// Optional response watchdog is enabled by defining MEM_READER_TIMEOUT_EN.

module ccip_mem_read_engine #(
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned LEN_W           = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [41:0]      base_addr,
    input  logic [LEN_W-1:0] num_lines,
    input  logic             c0_tx_alm_full,
    output logic             c0_req_valid,
    output logic [41:0]      c0_req_addr,
    output logic [15:0]      c0_req_mdata,
    input  logic             c0_rsp_valid,
    input  logic [15:0]      c0_rsp_mdata,
    input  logic [511:0]     c0_rsp_data,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [63:0]      checksum,
    output logic [LEN_W-1:0] lines_rcvd
);

    localparam int unsigned TAG_W   = $clog2(MAX_OUTSTANDING);
    localparam int unsigned ADDR_W  = 42;
    localparam int unsigned MDATA_W = 16;
    localparam int unsigned WORD_W  = 64;
    localparam int unsigned WORDS   = 512 / WORD_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                 state_q;
    logic [1:0]                 state_d;
    logic [ADDR_W-1:0]          base_q;
    logic [LEN_W-1:0]           len_q;
    logic [LEN_W-1:0]           issued_q;
    logic [MAX_OUTSTANDING-1:0] bitmap_q;
    logic [MAX_OUTSTANDING-1:0] bitmap_d;

    logic              start_c;
    logic              active_c;
    logic              issue_c;
    logic              accept_c;
    logic              stray_c;
    logic              timeout_c;
    logic              rsp_hi_zero_c;
    logic [TAG_W-1:0]  issue_tag_c;
    logic [TAG_W-1:0]  rsp_tag_c;
    logic [WORD_W-1:0] fold_c;

    assign issue_tag_c   = issued_q[TAG_W-1:0];
    assign rsp_tag_c     = c0_rsp_mdata[TAG_W-1:0];
    assign rsp_hi_zero_c = (c0_rsp_mdata[MDATA_W-1:TAG_W] == '0);
    assign active_c      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign start_c       = (state_q == ST_IDLE) && start;

    // Only a live tag of the current run is accepted; anything else is flagged.
    assign accept_c = c0_rsp_valid && active_c && rsp_hi_zero_c && bitmap_q[rsp_tag_c];
    assign stray_c  = c0_rsp_valid && !accept_c;

    always_comb begin
        fold_c = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            fold_c = fold_c ^ c0_rsp_data[i*WORD_W +: WORD_W];
        end
    end

`ifdef MEM_READER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            to_run_c;

    // Watchdog counts while reads are outstanding and no response makes progress.
    assign to_run_c  = active_c && (bitmap_q != '0) && !accept_c;
    assign timeout_c = to_run_c && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
        end else if (!active_c || accept_c || timeout_c) begin
            to_cnt_q <= '0;
        end else if (to_run_c) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign timeout_c          = 1'b0;
`endif

    // Next state and issue decision; issue sees the bitmap before this cycle's clear.
    always_comb begin
        state_d = state_q;
        issue_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_lines == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                issue_c = !c0_tx_alm_full && (issued_q < len_q) &&
                          !bitmap_q[issue_tag_c] && !timeout_c;
                if (issued_q == len_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (lines_rcvd == len_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (timeout_c) begin
            state_d = ST_DONE;
        end
    end

    always_comb begin
        bitmap_d = bitmap_q;
        if (accept_c) begin
            bitmap_d[rsp_tag_c] = 1'b0;
        end
        if (issue_c) begin
            bitmap_d[issue_tag_c] = 1'b1;
        end
        if (timeout_c) begin
            bitmap_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, request port and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q       <= '0;
            len_q        <= '0;
            issued_q     <= '0;
            bitmap_q     <= '0;
            c0_req_valid <= 1'b0;
            c0_req_addr  <= '0;
            c0_req_mdata <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            checksum     <= '0;
            lines_rcvd   <= '0;
        end else begin
            bitmap_q     <= bitmap_d;
            c0_req_valid <= issue_c;
            busy         <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done         <= (state_q == ST_DONE);

            if (start_c) begin
                base_q     <= base_addr;
                len_q      <= num_lines;
                issued_q   <= '0;
                lines_rcvd <= '0;
                checksum   <= '0;
                error      <= 1'b0;
            end

            if (issue_c) begin
                c0_req_addr  <= base_q + ADDR_W'(issued_q);
                c0_req_mdata <= MDATA_W'(issue_tag_c);
                issued_q     <= issued_q + LEN_W'(1);
            end

            if (accept_c) begin
                lines_rcvd <= lines_rcvd + LEN_W'(1);
                checksum   <= checksum ^ fold_c;
            end

            if (stray_c || timeout_c) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ccip_mem_read_engine.sv
// Bench for ccip_mem_read_engine: table of runs plus hand sequences for tag stall, async reset and stray responses.

module tb_ccip_mem_read_engine;

    localparam int unsigned MAX_OUT = 16;
    localparam int unsigned LEN_W   = 16;
    localparam int          BUDGET  = 2000;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [41:0]      base_addr;
    logic [LEN_W-1:0] num_lines;
    logic             c0_tx_alm_full;
    logic             c0_req_valid;
    logic [41:0]      c0_req_addr;
    logic [15:0]      c0_req_mdata;
    logic             c0_rsp_valid;
    logic [15:0]      c0_rsp_mdata;
    logic [511:0]     c0_rsp_data;
    logic             busy;
    logic             done;
    logic             error;
    logic [63:0]      checksum;
    logic [LEN_W-1:0] lines_rcvd;

    ccip_mem_read_engine #(
        .MAX_OUTSTANDING(MAX_OUT),
        .LEN_W          (LEN_W),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .base_addr     (base_addr),
        .num_lines     (num_lines),
        .c0_tx_alm_full(c0_tx_alm_full),
        .c0_req_valid  (c0_req_valid),
        .c0_req_addr   (c0_req_addr),
        .c0_req_mdata  (c0_req_mdata),
        .c0_rsp_valid  (c0_rsp_valid),
        .c0_rsp_mdata  (c0_rsp_mdata),
        .c0_rsp_data   (c0_rsp_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .checksum      (checksum),
        .lines_rcvd    (lines_rcvd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [41:0] addr;
        logic [15:0] mdata;
        int          due;
    } req_t;

    typedef struct {
        logic [41:0] base;
        int          nlines;
        int          rsp_delay;
        bit          reverse;
        int          alm_lo;
        int          alm_hi;
        int          drop_idx;
        int          exp_first;
        int          exp_span;
        bit          exp_error;
    } vec_t;

    req_t exp_q[$];
    req_t pend_q[$];

    int vectors       = 0;
    int miscompares   = 0;
    int cyc           = 0;
    int req_cnt       = 0;
    int first_req_cyc = -1;
    int last_req_cyc  = -1;
    int done_cnt      = 0;
    int done_cyc      = -1;
    int win_lo        = 0;
    int win_hi        = -1;
    int win_hits      = 0;
    int rsp_delay     = 0;

    function automatic logic [511:0] gen_line(input logic [41:0] a);
        logic [511:0] l;
        l = '0;
        for (int j = 0; j < 8; j++) begin
            l[j*64 +: 64] = {22'(j), a} ^ (64'h9E3779B97F4A7C15 * 64'(j + 1));
        end
        return l;
    endfunction

    function automatic logic [63:0] fold(input logic [511:0] d);
        logic [63:0] f;
        f = '0;
        for (int j = 0; j < 8; j++) begin
            f = f ^ d[j*64 +: 64];
        end
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic send_rsp(input req_t r);
        c0_rsp_valid = 1'b1;
        c0_rsp_mdata = r.mdata;
        c0_rsp_data  = gen_line(r.addr);
    endtask

    // Advance one cycle and score any request the DUT presents.
    task automatic tick();
        req_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (c0_req_valid) begin
            req_cnt++;
            if (req_cnt == 1) first_req_cyc = cyc;
            last_req_cyc = cyc;
            if (cyc >= win_lo && cyc <= win_hi) win_hits++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_req: got addr 0x%0h mdata 0x%0h, expected no request (cycle %0d)",
                         c0_req_addr, c0_req_mdata, cyc);
            end else begin
                e = exp_q.pop_front();
                check("req_addr", 64'(c0_req_addr), 64'(e.addr));
                check("req_mdata", 64'(c0_req_mdata), 64'(e.mdata));
                e.due = cyc + rsp_delay;
                pend_q.push_back(e);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic reset_score();
        exp_q.delete();
        pend_q.delete();
        req_cnt       = 0;
        first_req_cyc = -1;
        last_req_cyc  = -1;
        done_cnt      = 0;
        done_cyc      = -1;
        win_lo        = 0;
        win_hi        = -1;
        win_hits      = 0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [63:0] exp_sum;
        req_t        r;
        int          s;
        int          rel;
        int          n_ok;
        reset_score();
        rsp_delay = v.rsp_delay;
        exp_sum   = '0;
        n_ok      = 0;
        for (int i = 0; i < v.nlines; i++) begin
            r.addr  = v.base + 42'(i);
            r.mdata = 16'(i % MAX_OUT);
            r.due   = 0;
            exp_q.push_back(r);
            if (i != v.drop_idx) begin
                exp_sum = exp_sum ^ fold(gen_line(r.addr));
                n_ok++;
            end
        end
        if (v.alm_lo >= 0) begin
            win_lo = cyc + v.alm_lo + 1;
            win_hi = cyc + v.alm_hi + 1;
        end
        s         = cyc;
        start     = 1'b1;
        base_addr = v.base;
        num_lines = LEN_W'(v.nlines);
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(v.nlines != 0));
        check("error_cleared_by_start", 64'(error), 64'(0));
        while (done_cnt == 0 && cyc - s < BUDGET) begin
            rel            = cyc - s;
            c0_tx_alm_full = (rel >= v.alm_lo) && (rel <= v.alm_hi);
            c0_rsp_valid   = 1'b0;
            if (pend_q.size() != 0) begin
                if (v.reverse) begin
                    if (req_cnt == v.nlines) begin
                        r = pend_q.pop_back();
                        send_rsp(r);
                    end
                end else if (pend_q[0].due <= cyc) begin
                    r = pend_q.pop_front();
                    if (v.drop_idx < 0 || r.addr != v.base + 42'(v.drop_idx)) send_rsp(r);
                end
            end
            tick();
        end
        c0_tx_alm_full = 1'b0;
        c0_rsp_valid   = 1'b0;
        check("run_completed", 64'(done_cnt), 64'(1));
        repeat (4) tick();
        check("done_pulse_count", 64'(done_cnt), 64'(1));
        check("req_count", 64'(req_cnt), 64'(v.nlines));
        check("all_reqs_seen", 64'(exp_q.size()), 64'(0));
        check("lines_rcvd", 64'(lines_rcvd), 64'(n_ok));
        check("checksum", checksum, exp_sum);
        check("error", 64'(error), 64'(v.exp_error));
        check("busy_after_done", 64'(busy), 64'(0));
        if (v.nlines != 0) check("first_req_latency", 64'(first_req_cyc - s), 64'(v.exp_first));
        else check("zero_len_done_latency", 64'(done_cyc - s), 64'(2));
        if (v.exp_span >= 0) check("req_span", 64'(last_req_cyc - first_req_cyc), 64'(v.exp_span));
        if (v.alm_lo >= 0) check("no_req_under_alm_full", 64'(win_hits), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        vec_t v;
        req_t r;
        int   c;

        reset_n        = 1'b0;
        start          = 1'b0;
        base_addr      = '0;
        num_lines      = '0;
        c0_tx_alm_full = 1'b0;
        c0_rsp_valid   = 1'b0;
        c0_rsp_mdata   = '0;
        c0_rsp_data    = '0;

        vecs[0] = '{base: 42'h1000, nlines: 4, rsp_delay: 3, reverse: 1'b0, alm_lo: -1, alm_hi: -2,
                    drop_idx: -1, exp_first: 2, exp_span: 3, exp_error: 1'b0};
        vecs[1] = '{base: 42'h2000, nlines: 8, rsp_delay: 3, reverse: 1'b0, alm_lo: 3, alm_hi: 9,
                    drop_idx: -1, exp_first: 2, exp_span: 14, exp_error: 1'b0};
        vecs[2] = '{base: 42'h3000, nlines: 8, rsp_delay: 0, reverse: 1'b1, alm_lo: -1, alm_hi: -2,
                    drop_idx: -1, exp_first: 2, exp_span: 7, exp_error: 1'b0};
        vecs[3] = '{base: 42'h3FF_FFFF_FFFE, nlines: 4, rsp_delay: 1, reverse: 1'b0, alm_lo: -1, alm_hi: -2,
                    drop_idx: -1, exp_first: 2, exp_span: 3, exp_error: 1'b0};
        vecs[4] = '{base: 42'h40000, nlines: 40, rsp_delay: 20, reverse: 1'b0, alm_lo: -1, alm_hi: -2,
                    drop_idx: -1, exp_first: 2, exp_span: -1, exp_error: 1'b0};
        vecs[5] = '{base: 42'h55, nlines: 1, rsp_delay: 0, reverse: 1'b0, alm_lo: -1, alm_hi: -2,
                    drop_idx: -1, exp_first: 2, exp_span: 0, exp_error: 1'b0};
        vecs[6] = '{base: 42'h6000, nlines: 0, rsp_delay: 0, reverse: 1'b0, alm_lo: -1, alm_hi: -2,
                    drop_idx: -1, exp_first: 2, exp_span: -1, exp_error: 1'b0};

        repeat (3) tick();
        check("rst_req_valid", 64'(c0_req_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_checksum", checksum, 64'(0));
        check("rst_lines_rcvd", 64'(lines_rcvd), 64'(0));
        reset_n = 1'b1;
        tick();

        // Stray response while idle.
        r.addr  = 42'h777;
        r.mdata = 16'd7;
        r.due   = 0;
        send_rsp(r);
        tick();
        c0_rsp_valid = 1'b0;
        check("stray_idle_error", 64'(error), 64'(1));
        check("stray_idle_lines", 64'(lines_rcvd), 64'(0));
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Tag stall: 40 lines, nothing returned until tags are handed back one by one.
        reset_score();
        rsp_delay = 0;
        for (int i = 0; i < 40; i++) begin
            r.addr  = 42'h8000 + 42'(i);
            r.mdata = 16'(i % MAX_OUT);
            r.due   = 0;
            exp_q.push_back(r);
        end
        start     = 1'b1;
        base_addr = 42'h8000;
        num_lines = LEN_W'(40);
        tick();
        start = 1'b0;
        repeat (30) tick();
        check("stall_req_count", 64'(req_cnt), 64'(16));
        send_rsp(pend_q[5]);
        tick();
        c0_rsp_valid = 1'b0;
        repeat (6) tick();
        check("no_tag_skip", 64'(req_cnt), 64'(16));
        check("stall_lines_rcvd", 64'(lines_rcvd), 64'(1));
        c = cyc;
        send_rsp(pend_q[0]);
        tick();
        c0_rsp_valid = 1'b0;
        repeat (6) tick();
        check("tag0_reissue_count", 64'(req_cnt), 64'(17));
        check("tag0_reissue_latency", 64'(last_req_cyc - c), 64'(2));
        check("busy_mid_run", 64'(busy), 64'(1));

        // Asynchronous reset mid-run, then a late response for a pre-reset tag.
        reset_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_lines", 64'(lines_rcvd), 64'(0));
        check("async_rst_checksum", checksum, 64'(0));
        check("async_rst_error", 64'(error), 64'(0));
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        r.addr  = 42'h8003;
        r.mdata = 16'd3;
        send_rsp(r);
        tick();
        c0_rsp_valid = 1'b0;
        check("pre_reset_tag_error", 64'(error), 64'(1));
        check("pre_reset_tag_lines", 64'(lines_rcvd), 64'(0));
        tick();
        run_vec(vecs[0]);

`ifdef MEM_READER_TIMEOUT_EN
        v = '{base: 42'h9000, nlines: 4, rsp_delay: 3, reverse: 1'b0, alm_lo: -1, alm_hi: -2,
              drop_idx: 2, exp_first: 2, exp_span: 3, exp_error: 1'b1};
        run_vec(v);
`else
        v = vecs[5];
        run_vec(v);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
